fifo_buffer: RTL and testbench
==============================

# fifo_buffer

Parametrised synchronous FIFO for byte/word buffering between the serial link front-end and the packet logic. It has configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It also supports a simultaneous read and write when full. Storage is an internal inferred dual-port array with a registered read port.

## Interface

- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16384, number of words; power of two, ≥2
- ALMOST_FULL, DEPTH-2, almost_full asserted when count ≥ this value (1..DEPTH)
- ALMOST_EMPTY, 2, almost_empty asserted when count ≤ this value (0..DEPTH-1)
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  write data
- write  input  1  write request
- read  input  1  read request
- enable  input  1  global enable; when low, read and write are ignored (flush still acts)
- flush  input  1  synchronous clear of contents and flags
- data_out  output  WIDTH  registered read data
- data_valid  output  1  high for one cycle when data_out holds newly read word
- full, empty  output  1 each  occupancy = DEPTH / occupancy = 0
- almost_full, almost_empty  output  1 each  threshold flags
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1 each  sticky error flags

## Operation

- Internal pointers are wr_ptr and rd_ptr, each $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0. count is held in its own register and is never derived from pointer difference.
- rd_acc = read & enable & ~empty.
- wr_acc = write & enable & (~full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] ← data_in, and wr_ptr increments.
- On rd_acc: data_out ← mem[rd_ptr], and rd_ptr increments.
- A read on an empty FIFO is rejected even if a write is accepted in the same cycle. There is no fall-through.
- count next value:
  - +1 on wr_acc only
  - −1 on rd_acc only
  - unchanged when both or neither are accepted
- full, empty, almost_full and almost_empty are registered. They are computed from the next count value, so they change on the same edge as count.
- overflow sets when write & enable & ~wr_acc.
- underflow sets when read & enable & ~rd_acc.
- Both error flags hold until reset or flush.
- flush has priority over read and write in the same cycle. It clears the following to their reset values: pointers, count, full, empty, almost flags, overflow, underflow and data_valid.
- data_out holds its value through a flush. Memory contents are not cleared.
- Reset values: data_out 0, data_valid 0, full 0, empty 1, almost_full 0 (or 1 only if ALMOST_FULL=0, which is illegal), almost_empty 1, count 0, overflow 0, underflow 0, pointers 0. The memory array is not reset.

## Timing

- Write-to-read latency: a word written on edge N can be read-accepted on edge N+1, since empty deasserts after edge N.
- Read latency: data_out and data_valid are valid in the cycle after the edge that accepts the read. data_valid is high for exactly one cycle per rd_acc.
- Back-to-back reads give one word per cycle, with data_valid held high continuously.
- Reset asserting mid-operation forces all outputs to reset values immediately (asynchronous). Operation resumes on the first rising edge after reset deasserts.
- Simultaneous read+write at count=DEPTH: both are accepted, count stays DEPTH, full stays 1, and overflow does not set.
- Simultaneous read+write at count=0: the write is accepted, the read is rejected, count becomes 1, and underflow sets.
- Pointer wrap needs no special handling. The word at address DEPTH-1 is followed by the word at address 0.

## Test plan

- Reset then fill (WIDTH=8, DEPTH=16): write 0x00..0x0F on consecutive cycles. After the 14th write, almost_full=1. After the 16th, full=1, count=16 and overflow=0.
- Overflow: at full, write 0xAA with no read. Required: count stays 16, overflow=1, and a later read returns 0x00, not 0xAA.
- Drain and underflow: read 16 times. Required: data_out sequence 0x00..0x0F, each one cycle after its read, with data_valid high for 16 cycles. Then empty=1, almost_empty=1, and a 17th read sets underflow while data_valid stays 0.
- Wrap and simultaneous access at full: fill 16, then do 20 cycles of read+write with data 0x10..0x23. Required: count constant at 16, full=1, outputs 0x00..0x13 in order, no error flags.
- Simultaneous access at empty: with count=0, read+write 0x55 in the same cycle. Required: count=1, underflow=1, data_valid=0. The next read returns 0x55.
- Flush and async reset: with count=9 and overflow set, pulse flush together with write. Required: count=0, empty=1, overflow=0, and the write is discarded. Then, with the FIFO partially filled, drop reset between edges. Required: all outputs go to reset values before the next edge.

Source files
------------

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Read data appears one cycle after an accepted read; writes when full are refused unless a read is accepted alongside.
module fifo_buffer #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16384,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     write,
  input  logic                     read,
  input  logic                     enable,
  input  logic                     flush,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY);
  localparam logic          AF_RST  = (ALMOST_FULL == 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_req;
  logic             rd_req;
  logic [CW-1:0]    count_nxt;

  assign wr_req = write & enable;
  assign rd_req = read & enable;

  // Flush wins over both ports, so it is folded into the accept terms.
  assign rd_acc = rd_req & ~empty & ~flush;
  assign wr_acc = wr_req & (~full | rd_acc) & ~flush;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      // data_out deliberately keeps the last word read.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_valid   <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      data_valid   <= rd_acc;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (wr_req & ~wr_acc) overflow  <= 1'b1;
      if (rd_req & ~rd_acc) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed and randomized checks of fifo_buffer against a queue-based reference model.
module tb_fifo_buffer;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_in;
  logic         write;
  logic         read;
  logic         enable;
  logic         flush;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv;
  logic       m_ovf;
  logic       m_udf;

  fifo_buffer #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .write(write), .read(read),
    .enable(enable), .flush(flush), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ":data_valid"},   32'(data_valid),   32'(m_dv));
    chk({tag, ":count"},        32'(count),        32'(q.size()));
    chk({tag, ":full"},         32'(full),         32'(q.size() == D));
    chk({tag, ":empty"},        32'(empty),        32'(q.size() == 0));
    chk({tag, ":almost_full"},  32'(almost_full),  32'(q.size() >= AF));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ":underflow"},    32'(underflow),    32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, compare everything.
  task automatic step(input string tag, input logic w, input logic r, input logic en,
                      input logic fl, input logic [7:0] d);
    logic rd_ok;
    logic wr_ok;
    write = w; read = r; enable = en; flush = fl; data_in = d;
    @(posedge clock);
    #1;
    if (fl) begin
      q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = r && en && (q.size() > 0);
      wr_ok = w && en && ((q.size() < D) || rd_ok);
      m_dv  = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (w && en && !wr_ok) m_ovf = 1'b1;
      if (r && en && !rd_ok) m_udf = 1'b1;
    end
    check_all(tag);
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int wp;
    int rp;
    reset = 1'b0; write = 1'b0; read = 1'b0; enable = 1'b0; flush = 1'b0; data_in = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // fill
    for (int i = 0; i < D; i++) begin
      step("fill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 12) chk("fill13_af", 32'(almost_full), 32'd0);
      if (i == 13) chk("fill14_af", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd0);

    // overflow at full
    step("ovf", 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);

    // drain, then underflow
    for (int i = 0; i < D; i++) begin
      step("drain", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("drain_data", 32'(data_out), 32'(i));
    end
    step("udf", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_dv", 32'(data_valid), 32'd0);

    // wrap with simultaneous read+write at full
    step("flush1", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < D; i++) step("fill2", 1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 20; i++) begin
      step("rw_full", 1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      chk("rw_full_data", 32'(data_out), 32'(i));
      chk("rw_full_cnt", 32'(count), 32'd16);
    end
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    chk("rw_full_udf", 32'(underflow), 32'd0);

    // simultaneous read+write at empty
    step("flush2", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    step("rw_empty", 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
    chk("rw_empty_cnt", 32'(count), 32'd1);
    chk("rw_empty_udf", 32'(underflow), 32'd1);
    chk("rw_empty_dv", 32'(data_valid), 32'd0);
    step("rd55", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("rd55_data", 32'(data_out), 32'h55);

    // flush beats a concurrent write
    step("flush3", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < D; i++) step("fill3", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step("ovf3", 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < 7; i++) step("rd7", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("pre_flush_cnt", 32'(count), 32'd9);
    chk("pre_flush_ovf", 32'(overflow), 32'd1);
    step("flush_wr", 1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    step("post_flush_rd", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // enable low ignores both ports
    step("dis_wr", 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);

    // randomized phases alternating fill-heavy and drain-heavy traffic
    for (int i = 0; i < 800; i++) begin
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      d  = 8'($urandom);
      step("rand",
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < rp,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 149) == 0,
           d);
    end

    // async reset mid-cycle with the FIFO partly full
    step("flush4", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step("pfill", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step("prd", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    write = 1'b0; read = 1'b0; enable = 1'b0; flush = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    reset = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) step("post_rst_wr", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 4; i++) step("post_rst_rd", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
